// File: rtl/decoder_sequenced_3to8.sv
// Registered 3-to-8 decoder with programmable hold and idle gap (active-low I/O).
// Optional one-entry pending buffer enabled by defining DECODER_PENDING_EN.
module decoder_sequenced_3to8 #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       enable_in_,
  input  logic [2:0] signal_i_,
  input  logic       group_signal_,
  output logic [7:0] signal_o_,
  output logic       busy_,
  output logic       enable_out_,
  output logic       drop_,
  output logic [1:0] state_dbg
);

  // Handshake: a request is a rising edge that samples enable_in_=0 and
  // group_signal_=0; it is accepted in IDLE, buffered or dropped otherwise.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

`ifdef DECODER_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] index_q, index_d;
  logic       pend_valid, pend_valid_d;
  logic [2:0] pend_index, pend_index_d;
  logic       req, abort, launch_pend, capture, store, drop_now;
  logic [7:0] sig_d;
  logic       busy_d;

  assign req   = !enable_in_ && !group_signal_;
  assign abort = enable_in_ && (state_q != IDLE);

  // State register, including the registered outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      index_q    <= 3'd0;
      pend_valid <= 1'b0;
      pend_index <= 3'd0;
      signal_o_  <= 8'hFF;
      busy_      <= 1'b1;
      drop_      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      index_q    <= index_d;
      pend_valid <= pend_valid_d;
      pend_index <= pend_index_d;
      signal_o_  <= sig_d;
      busy_      <= busy_d;
      drop_      <= !drop_now;
    end
  end

  // Next-state logic; a drained pending entry launches HOLD with no idle cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    index_d     = index_q;
    launch_pend = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid) begin
          state_d     = HOLD;
          cnt_d       = HOLD_LOAD;
          index_d     = pend_index;
          launch_pend = 1'b1;
        end else if (req) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          index_d = ~signal_i_;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (GAP_CYCLES != 0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else if (pend_valid) begin
          cnt_d       = HOLD_LOAD;
          index_d     = pend_index;
          launch_pend = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (pend_valid) begin
          state_d     = HOLD;
          cnt_d       = HOLD_LOAD;
          index_d     = pend_index;
          launch_pend = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Requests that cannot start a HOLD directly are buffered or dropped.
  always_comb begin
    capture      = req && ((state_q != IDLE) || pend_valid);
    store        = PEND_EN && capture && (!pend_valid || launch_pend);
    drop_now     = capture && !store;
    pend_valid_d = pend_valid;
    pend_index_d = pend_index;
    if (abort) begin
      pend_valid_d = 1'b0;
    end else if (store) begin
      pend_valid_d = 1'b1;
      pend_index_d = ~signal_i_;
    end else if (launch_pend) begin
      pend_valid_d = 1'b0;
    end
  end

  // Output logic: values registered alongside the state they describe.
  always_comb begin
    sig_d  = 8'hFF;
    busy_d = (state_d == IDLE);
    if (state_d == HOLD) begin
      sig_d = ~(8'd1 << index_d);
    end
  end

  assign enable_out_ = !(reset_ && !enable_in_ && (state_q == IDLE) && group_signal_);
  assign state_dbg   = state_q;

endmodule
